// File: rtl/clk_ctrl_pkg.sv
// clk_ctrl_pkg: shared state encoding and key indices for the CPU clock controller
package clk_ctrl_pkg;
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    HALT    = 2'd1,
    STEP_HI = 2'd2,
    STEP_LO = 2'd3
  } clk_state_e;
  localparam int KEY_RUN  = 0;
  localparam int KEY_STEP = 1;
  localparam int KEY_HALT = 3;
endpackage

// File: rtl/key_debounce.sv
// key_debounce: synchronises an active-low key, debounces it and emits a 1-cycle press pulse
// Ports: clk_i clock, rst_i sync active-high reset, key_n_i raw active-low key,
//        press_o one-cycle pulse when the debounced key goes released->pressed.
module key_debounce #(
  parameter int CYCLES = 500000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_n_i,
  output logic press_o
);
  localparam int CW = $clog2(CYCLES + 1);
  logic [1:0]    sync_q;
  logic          stable_q, stable_d, press_q, press_d, differ, done;
  logic [CW-1:0] cnt_q, cnt_d;
  // The debounced level only moves after CYCLES consecutive samples disagree with it.
  always_comb begin
    differ   = sync_q[1] != stable_q;
    done     = cnt_q == CW'(CYCLES - 1);
    cnt_d    = differ ? (done ? '0 : cnt_q + 1'b1) : '0;
    stable_d = (differ && done) ? sync_q[1] : stable_q;
    press_d  = differ && done && !sync_q[1];
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q   <= 2'b11;
      stable_q <= 1'b1;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], key_n_i};
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end
  assign press_o = press_q;
endmodule

// File: rtl/cpu_clock_step_control.sv
// cpu_clock_step_control: divided processor clock with breakpoint halt, single step and resume
// Ports: iCLK_50 board clock, Reset sync active-high, iKEY active-low keys ([0] RUN,
//        [1] STEP, [3] HALT), iBreak breakpoint request, iDivSel half-period = 2**iDivSel,
//        oCPU_CLK processor clock, oCPU_RISE strobe on each 0->1, oHalted, oState debug,
//        oCycles rising-edge count.
// Optional: define CLK_CYCLE_COUNT_EN to build the oCycles counter (otherwise tied to 0).
module cpu_clock_step_control
  import clk_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DIVSEL_W        = 5,
  parameter bit START_HALTED    = 1'b0
) (
  input  logic                iCLK_50,
  input  logic                Reset,
  input  logic [3:0]          iKEY,
  input  logic                iBreak,
  input  logic [DIVSEL_W-1:0] iDivSel,
  output logic                oCPU_CLK,
  output logic                oCPU_RISE,
  output logic                oHalted,
  output logic [1:0]          oState,
  output logic [31:0]         oCycles
);
  localparam int CNT_W = 2 ** DIVSEL_W;
  clk_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, limit;
  logic             clk_q, clk_d, rise_q, rise_d, mask_q, mask_d, hp_q, hp_d;
  logic             brk_q1, brk_s, term, run_p, step_p, halt_p;
  logic             unused_key;
  assign unused_key = iKEY[2];
  key_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_run  (.clk_i(iCLK_50), .rst_i(Reset), .key_n_i(iKEY[KEY_RUN]),  .press_o(run_p));
  key_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_step (.clk_i(iCLK_50), .rst_i(Reset), .key_n_i(iKEY[KEY_STEP]), .press_o(step_p));
  key_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_halt (.clk_i(iCLK_50), .rst_i(Reset), .key_n_i(iKEY[KEY_HALT]), .press_o(halt_p));
  // >= rather than == so that shrinking iDivSel mid-phase ends the phase at once.
  assign limit = (CNT_W'(1) << iDivSel) - CNT_W'(1);
  assign term  = cnt_q >= limit;
  always_comb begin
    state_d = state_q;
    clk_d   = clk_q;
    rise_d  = 1'b0;
    mask_d  = mask_q;
    hp_d    = 1'b0;
    cnt_d   = term ? '0 : cnt_q + 1'b1;
    case (state_q)
      RUN: begin
        hp_d = hp_q | halt_p | (brk_s & ~mask_q);
        // Halting only from the low phase keeps the CPU from being frozen mid-high.
        if (term) begin
          if (!clk_q && hp_d) begin
            state_d = HALT;
            hp_d    = 1'b0;
          end else begin
            clk_d  = ~clk_q;
            rise_d = ~clk_q;
            mask_d = mask_q & ~clk_q;
          end
        end
      end
      HALT: begin
        clk_d = 1'b0;
        cnt_d = '0;
        if (step_p) begin
          state_d = STEP_HI;
          clk_d   = 1'b1;
          rise_d  = 1'b1;
        end else if (run_p) begin
          state_d = RUN;
          mask_d  = 1'b1;
        end
      end
      STEP_HI: if (term) begin
        state_d = STEP_LO;
        clk_d   = 1'b0;
      end
      STEP_LO: if (term) state_d = HALT;
    endcase
  end
  always_ff @(posedge iCLK_50) begin
    if (Reset) begin
      state_q <= START_HALTED ? HALT : RUN;
      cnt_q   <= '0;
      clk_q   <= 1'b0;
      rise_q  <= 1'b0;
      mask_q  <= 1'b0;
      hp_q    <= 1'b0;
      brk_q1  <= 1'b0;
      brk_s   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clk_q   <= clk_d;
      rise_q  <= rise_d;
      mask_q  <= mask_d;
      hp_q    <= hp_d;
      brk_q1  <= iBreak;
      brk_s   <= brk_q1;
    end
  end
  assign oCPU_CLK  = clk_q;
  assign oCPU_RISE = rise_q;
  assign oHalted   = state_q == HALT;
  assign oState    = state_q;
`ifdef CLK_CYCLE_COUNT_EN
  logic [31:0] cyc_q;
  always_ff @(posedge iCLK_50) cyc_q <= Reset ? '0 : cyc_q + {31'd0, rise_q};
  assign oCycles = cyc_q;
`else
  assign oCycles = 32'd0;
`endif
endmodule

// File: tb/tb_cpu_clock_step_control.sv
// tb_cpu_clock_step_control: randomized self-checking bench for the CPU clock controller
module tb_cpu_clock_step_control;
  logic        clk = 1'b0, Reset = 1'b1, iBreak = 1'b0;
  logic [3:0]  iKEY = 4'hF;
  logic [4:0]  iDivSel = 5'd2;
  logic        oCPU_CLK, oCPU_RISE, oHalted;
  logic [1:0]  oState;
  logic [31:0] oCycles;
  int total = 0, bad = 0;
  int strobes = 0, falls = 0, rise_err = 0, run_len = 0, last_hi = 0, last_lo = 0;
  logic prev_clk = 1'b0;
  cpu_clock_step_control #(.DEBOUNCE_CYCLES(4), .DIVSEL_W(5), .START_HALTED(1'b0)) dut (
    .iCLK_50(clk), .Reset(Reset), .iKEY(iKEY), .iBreak(iBreak), .iDivSel(iDivSel),
    .oCPU_CLK(oCPU_CLK), .oCPU_RISE(oCPU_RISE), .oHalted(oHalted), .oState(oState),
    .oCycles(oCycles)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (oCPU_RISE != (oCPU_CLK && !prev_clk)) rise_err++;
    if (oCPU_RISE) strobes++;
    if (!oCPU_CLK && prev_clk) falls++;
    if (oCPU_CLK == prev_clk) run_len++;
    else begin
      if (prev_clk) last_hi = run_len;
      else last_lo = run_len;
      run_len = 1;
    end
    prev_clk = oCPU_CLK;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask
  task automatic wait_rise(input string tag, input int lim);
    int s = strobes;
    int n = 0;
    while (strobes == s && n < lim) begin
      tick(1);
      n++;
    end
    check({tag, "_rise_seen"}, (strobes != s) ? 1 : 0, 1);
  endtask
  task automatic wait_fall(input string tag, input int lim);
    int s = falls;
    int n = 0;
    while (falls == s && n < lim) begin
      tick(1);
      n++;
    end
    check({tag, "_fall_seen"}, (falls != s) ? 1 : 0, 1);
  endtask
  task automatic wait_halt(output int n);
    n = 0;
    while (!oHalted && n < 40) begin
      tick(1);
      n++;
    end
  endtask
  task automatic do_step(input int d);
    int s, n;
    iDivSel = d[4:0];
    s = strobes;
    iKEY[1] = 1'b0;
    wait_rise("step", 30);
    wait_halt(n);
    check("step_len", n, 2 << d);
    check("step_hi", last_hi, 1 << d);
    iKEY[1] = 1'b1;
    tick(12);
    check("step_once", strobes - s, 1);
    check("step_clk", 32'(oCPU_CLK), 0);
    check("step_state", 32'(oState), 1);
  endtask
  initial begin
    int s, n, d;
    tick(4);
    check("rst_clk", 32'(oCPU_CLK), 0);
    check("rst_rise", 32'(oCPU_RISE), 0);
    check("rst_state", 32'(oState), 0);
    check("rst_halted", 32'(oHalted), 0);
    check("rst_cycles", oCycles, 0);
    Reset = 1'b0;
    wait_rise("run0", 20);
    s = strobes;
    tick(64);
    check("run_rises", strobes - s, 8);
    check("run_hi", last_hi, 4);
    check("run_lo", last_lo, 4);
    for (int i = 0; i < 4; i++) begin
      d = $urandom_range(0, 3);
      iDivSel = d[4:0];
      tick(8 + 4 * (1 << d) + 2);
      check("div_hi", last_hi, 1 << d);
      check("div_lo", last_lo, 1 << d);
    end
    iDivSel = 5'd2;
    wait_fall("brk", 20);
    iBreak = 1'b1;
    s = strobes;
    tick(12);
    check("brk_halted", 32'(oHalted), 1);
    check("brk_state", 32'(oState), 1);
    check("brk_clk", 32'(oCPU_CLK), 0);
    check("brk_no_rise", strobes - s, 0);
    do_step(1);
    for (int i = 0; i < 3; i++) do_step($urandom_range(0, 2));
    iDivSel = 5'd2;
    iKEY[0] = 1'b0;
    wait_rise("resume", 30);
    check("resume_state", 32'(oState), 0);
    iBreak = 1'b0;
    wait_fall("resume", 20);
    tick(10);
    check("no_rehalt", 32'(oState), 0);
    iKEY[0] = 1'b1;
    tick(10);
    wait_fall("brk2", 20);
    iBreak = 1'b1;
    tick(1);
    iBreak = 1'b0;
    tick(12);
    check("brk2_halted", 32'(oHalted), 1);
    check("brk2_clk", 32'(oCPU_CLK), 0);
    iKEY[0] = 1'b0;
    wait_rise("run2", 30);
    iKEY[0] = 1'b1;
    tick(10);
    iKEY[3] = 1'b0;
    tick(10);
    iKEY[3] = 1'b1;
    tick(20);
    check("hkey_halted", 32'(oHalted), 1);
    check("hkey_clk", 32'(oCPU_CLK), 0);
    s = strobes;
    tick(20);
    check("hkey_stopped", strobes - s, 0);
    iKEY[1] = 1'b0;
    tick(2);
    iKEY[1] = 1'b1;
    tick(1);
    iKEY[1] = 1'b0;
    tick(2);
    iKEY[1] = 1'b1;
    tick(12);
    check("bounce_rises", strobes - s, 0);
    check("bounce_state", 32'(oState), 1);
    s = strobes;
    iKEY[1:0] = 2'b00;
    wait_rise("both", 30);
    wait_halt(n);
    check("both_len", n, 8);
    iKEY[1:0] = 2'b11;
    tick(12);
    check("both_rises", strobes - s, 1);
    check("both_state", 32'(oState), 1);
    iDivSel = 5'd3;
    iKEY[1] = 1'b0;
    wait_rise("rst_step", 30);
    tick(2);
    Reset = 1'b1;
    iKEY[1] = 1'b1;
    tick(1);
    check("rst_step_clk", 32'(oCPU_CLK), 0);
    check("rst_step_state", 32'(oState), 0);
    check("rst_step_cycles", oCycles, 0);
    tick(6);
    Reset = 1'b0;
    s = strobes;
`ifdef CLK_CYCLE_COUNT_EN
    iDivSel = 5'd1;
    tick(30);
    wait_fall("cyc", 10);
    check("cycles", oCycles, strobes - s);
`else
    tick(10);
    check("cycles_off", oCycles, 0);
`endif
    check("rise_strobe", rise_err, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
